apb4_slave_regfile: RTL and testbench

// - APB4 completer: a word-addressed register file behind one PSELx leg of the APB4 decoder.
// - Drives PRDATA/PREADY/PSLVERR back into the decoder's per-slave return inputs.
// - Supports programmable wait states, byte strobes, error response and a read-only ID word.

---
 rtl/apb4_slave_regfile.sv | 147 ++++++++++++++
 tb/tb_apb4_slave_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/apb4_slave_regfile.sv
// APB4 completer: word-addressed register file with wait states, strobes and ID word.
// Optional macro APB4_PROT_CHECK_EN rejects unprivileged writes (PPROT[0]=0).
module apb4_slave_regfile #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA4B4_0001
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [2:0]              PPROT,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int unsigned SW = DATA_WIDTH / 8;
   localparam int unsigned IW = ADDR_WIDTH - 2;

   typedef enum logic {IDLE, ACCESS} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [SW-1:0]         strb_q, strb_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] wmask;
   logic [DATA_WIDTH-1:0] rd_or [0:NUM_REGS-1];
   logic [IW-1:0]         idx;
   logic                  ready;
   logic                  err;
   logic                  commit;

`ifdef APB4_PROT_CHECK_EN
   logic prot_q, prot_d;
   logic unused_prot;
   assign unused_prot = ^PPROT[2:1];
`else
   logic unused_prot;
   assign unused_prot = ^PPROT;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      strb_d  = strb_q;
      wdata_d = wdata_q;
`ifdef APB4_PROT_CHECK_EN
      prot_d  = prot_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_CYCLES);
               addr_d  = PADDR;
               write_d = PWRITE;
               strb_d  = PSTRB;
               wdata_d = PWDATA;
`ifdef APB4_PROT_CHECK_EN
               prot_d  = PPROT[0];
`endif
            end
         end
         ACCESS: begin
            if (!PSEL || cnt_q == 4'd0) state_d = IDLE;
            else cnt_d = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         strb_q  <= '0;
         wdata_q <= '0;
`ifdef APB4_PROT_CHECK_EN
         prot_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         strb_q  <= strb_d;
         wdata_q <= wdata_d;
`ifdef APB4_PROT_CHECK_EN
         prot_q  <= prot_d;
`endif
      end
   end

   assign idx   = addr_q[ADDR_WIDTH-1:2];
   assign ready = (state_q == ACCESS) && (cnt_q == 4'd0);

   always_comb begin
      err = (addr_q[1:0] != 2'b00)
         || (32'(idx) >= NUM_REGS)
         || (write_q && idx == '0);
`ifdef APB4_PROT_CHECK_EN
      if (write_q && !prot_q) err = 1'b1;
`endif
   end

   // PSEL is sampled only to suppress the commit of an abandoned transfer
   assign commit = ready && PSEL && write_q && !err;

   for (genvar b = 0; b < SW; b++) begin : g_mask
      assign wmask[8*b +: 8] = {8{strb_q[b]}};
   end

   assign rd_or[0] = (idx == '0) ? ID_VALUE : '0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;
      logic                  hit;

      assign hit = (32'(idx) == 32'(g));

      always_ff @(posedge PCLK or negedge PRESETn) begin
         if (!PRESETn) data_q <= '0;
         else if (commit && hit)
            data_q <= (data_q & ~wmask) | (wdata_q & wmask);
      end

      assign rd_or[g] = rd_or[g-1] | (hit ? data_q : '0);
   end

   assign PREADY  = ready;
   assign PSLVERR = ready && err;
   assign PRDATA  = (ready && !write_q && !err) ? rd_or[NUM_REGS-1] : '0;

endmodule

// File: tb/tb_apb4_slave_regfile.sv
// Bench for apb4_slave_regfile: zero-wait and 3-wait instances on one clock.
// Expectations track APB4_PROT_CHECK_EN when it is defined for the build.
module tb_apb4_slave_regfile;

   localparam int W1 = 3;
`ifdef APB4_PROT_CHECK_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      int          waits;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n   [2];
   logic        psel    [2];
   logic        penable [2];
   logic        pwrite  [2];
   logic [7:0]  paddr   [2];
   logic [31:0] pwdata  [2];
   logic [3:0]  pstrb   [2];
   logic [2:0]  pprot   [2];
   logic [31:0] prdata  [2];
   logic        pready  [2];
   logic        pslverr [2];

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl[19];

   always #5 clk = ~clk;

   apb4_slave_regfile #(.WAIT_CYCLES(0)) u0 (
      .PCLK(clk), .PRESETn(rst_n[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
      .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
      .PSTRB(pstrb[0]), .PPROT(pprot[0]), .PRDATA(prdata[0]),
      .PREADY(pready[0]), .PSLVERR(pslverr[0])
   );

   apb4_slave_regfile #(.WAIT_CYCLES(W1)) u1 (
      .PCLK(clk), .PRESETn(rst_n[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
      .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
      .PSTRB(pstrb[1]), .PPROT(pprot[1]), .PRDATA(prdata[1]),
      .PREADY(pready[1]), .PSLVERR(pslverr[1])
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
   endtask

   // Drives one transfer starting at the next falling edge; returns at
   // the falling edge where PREADY was seen, so a following call is back-to-back.
   task automatic xfer(input int d, input vec_t v, input string name);
      exp_t e;
      int   waits;
      bit   bad;
      sb_q.push_back('{v.exp_rdata, v.exp_err, (d == 0) ? 0 : W1});
      @(negedge clk);
      psel[d]    = 1'b1;
      penable[d] = 1'b0;
      pwrite[d]  = v.wr;
      paddr[d]   = v.addr;
      pwdata[d]  = v.wdata;
      pstrb[d]   = v.strb;
      pprot[d]   = v.prot;
      @(negedge clk);
      penable[d] = 1'b1;
      // setup values are latched, so disturbing the bus now must not matter
      pwrite[d]  = ~v.wr;
      paddr[d]   = ~v.addr;
      pwdata[d]  = $urandom;
      pstrb[d]   = ~v.strb;
      pprot[d]   = ~v.prot;
      waits = 0;
      bad   = 1'b0;
      while (!pready[d] && waits < 40) begin
         if (pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) bad = 1'b1;
         @(negedge clk);
         waits++;
      end
      e = sb_q.pop_front();
      check({name, " ready"}, 32'(pready[d]), 32'd1);
      check({name, " waits"}, waits, e.waits);
      check({name, " rdata"}, prdata[d], e.rdata);
      check({name, " err"}, 32'(pslverr[d]), 32'(e.err));
      check({name, " wait-outs"}, 32'(bad), 32'd0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0;
         pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
         pstrb[d] = '0; pprot[d] = '0;
      end

      tbl[0]  = '{0, 8'h00, 32'h0, 4'h0, 3'b001, 32'hA4B40001, 0};
      tbl[1]  = '{1, 8'h04, 32'hDEADBEEF, 4'hF, 3'b001, 32'h0, 0};
      tbl[2]  = '{0, 8'h04, 32'h0, 4'h0, 3'b001, 32'hDEADBEEF, 0};
      tbl[3]  = '{1, 8'h04, 32'h11223344, 4'b0101, 3'b001, 32'h0, 0};
      tbl[4]  = '{0, 8'h04, 32'h0, 4'h0, 3'b001, 32'hDE22BE44, 0};
      tbl[5]  = '{0, 8'h40, 32'h0, 4'h0, 3'b001, 32'h0, 1};
      tbl[6]  = '{1, 8'h06, 32'hFFFFFFFF, 4'hF, 3'b001, 32'h0, 1};
      tbl[7]  = '{0, 8'h04, 32'h0, 4'h0, 3'b001, 32'hDE22BE44, 0};
      tbl[8]  = '{1, 8'h00, 32'h12345678, 4'hF, 3'b001, 32'h0, 1};
      tbl[9]  = '{0, 8'h00, 32'h0, 4'h0, 3'b001, 32'hA4B40001, 0};
      tbl[10] = '{1, 8'h08, 32'h00000005, 4'hF, 3'b001, 32'h0, 0};
      tbl[11] = '{0, 8'h08, 32'h0, 4'h0, 3'b001, 32'h00000005, 0};
      tbl[12] = '{1, 8'h0C, 32'h0000AAAA, 4'hF, 3'b000, 32'h0, PROT};
      tbl[13] = '{0, 8'h0C, 32'h0, 4'h0, 3'b001,
                  PROT ? 32'h0 : 32'h0000AAAA, 0};
      tbl[14] = '{1, 8'h0C, 32'h0000BBBB, 4'hF, 3'b001, 32'h0, 0};
      tbl[15] = '{0, 8'h0C, 32'h0, 4'h0, 3'b001, 32'h0000BBBB, 0};
      tbl[16] = '{1, 8'h10, 32'hFFFFFFFF, 4'h0, 3'b001, 32'h0, 0};
      tbl[17] = '{0, 8'h10, 32'h0, 4'h0, 3'b001, 32'h0, 0};
      tbl[18] = '{0, 8'h3C, 32'h0, 4'h0, 3'b001, 32'h0, 0};

      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst%0d ready", d), 32'(pready[d]), 32'd0);
         check($sformatf("rst%0d err", d), 32'(pslverr[d]), 32'd0);
         check($sformatf("rst%0d rdata", d), prdata[d], 32'h0);
      end
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      foreach (tbl[i]) xfer(0, tbl[i], $sformatf("v%0d", i));
      idle(0);

      xfer(1, '{1, 8'h04, 32'hCAFEF00D, 4'hF, 3'b001, 32'h0, 0}, "w3 wr");
      xfer(1, '{0, 8'h04, 32'h0, 4'h0, 3'b001, 32'hCAFEF00D, 0}, "w3 rd");
      idle(1);

      // reset pulsed in the second wait cycle of a write
      @(negedge clk);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
      paddr[1] = 8'h08; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
      pprot[1] = 3'b001;
      @(negedge clk);
      penable[1] = 1'b1;
      @(negedge clk);
      rst_n[1] = 1'b0;
      #1;
      check("midrst ready", 32'(pready[1]), 32'd0);
      check("midrst err", 32'(pslverr[1]), 32'd0);
      check("midrst rdata", prdata[1], 32'h0);
      psel[1] = 1'b0; penable[1] = 1'b0;
      @(negedge clk);
      rst_n[1] = 1'b1;
      xfer(1, '{0, 8'h08, 32'h0, 4'h0, 3'b001, 32'h0, 0}, "midrst r08");
      xfer(1, '{0, 8'h04, 32'h0, 4'h0, 3'b001, 32'h0, 0}, "midrst r04");
      idle(1);

      // PSEL dropped mid-ACCESS; next setup must be taken straight from IDLE
      @(negedge clk);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
      paddr[1] = 8'h0C; pwdata[1] = 32'h00000077; pstrb[1] = 4'hF;
      pprot[1] = 3'b001;
      @(negedge clk);
      penable[1] = 1'b1;
      @(negedge clk);
      psel[1] = 1'b0; penable[1] = 1'b0;
      xfer(1, '{0, 8'h0C, 32'h0, 4'h0, 3'b001, 32'h0, 0}, "drop r0C");
      idle(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

endmodule
